multi_digit_adder_display: RTL and testbench
============================================

# multi_digit_adder_display

Parametrised adder/subtractor with a time-multiplexed multi-digit hex seven-segment display. Operands are captured on a load strobe, and the registered result is shown across `DIGITS` common-anode digits with a free-running scan. Leading zeros are blanked. Carry and signed overflow are flagged. It is the board-level arithmetic demo block and replaces the single-digit, 4-bit combinational adder display.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be at least 4 and a multiple of 4.
- `DIGITS`, default 4: number of physical digits; must be at least WIDTH/4.
- `REFRESH_DIV`, default 100000: clock cycles each digit stays active; must be at least 2.
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: asynchronous, active-high reset.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `sub` in 1: 0 selects A+B, 1 selects A−B.
- `load` in 1: single-cycle capture strobe for `a`, `b` and `sub`.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `an` out DIGITS: digit enables, active-low, one-hot-low or all-high.
- `carry` out 1: add mode carries the carry-out; sub mode is 1 when no borrow occurs.
- `overflow` out 1: two's-complement signed overflow.
- `valid` out 1: high once the first result has been computed after reset.

## Operation
- **Capture.** When `load`=1 at a rising edge, `a`, `b` and `sub` are registered. A `load` held high recaptures on every cycle.
- **Compute.** The captured operands feed the arithmetic register on the next edge: result = opA + (sub ? ~opB : opB) + sub, computed at WIDTH+1 bits.
  - `carry` is bit WIDTH of that sum.
  - `overflow` = (opA[MSB] == opB'[MSB]) && (result[MSB] != opA[MSB]), where opB' is the inverted-or-not B.
- **Result register.** The result, `carry` and `overflow` hold until the next compute. `valid` is set by the first compute and cleared only by `reset`.
- **Scan.** A divider counter runs 0..REFRESH_DIV−1. On its wrap, the digit index advances; index DIGITS−1 wraps to 0.
- **Digit drive.** Digit i shows nibble result[4i+3:4i] when i < WIDTH/4.
  - Digits at or above WIDTH/4 are blanked: anode high, segments all 1.
- **Leading-zero blanking.** Digit i > 0 is blanked if it and every higher in-range nibble are zero. Digit 0 always shows.
  - A blanked digit keeps its scan slot, so timing is uniform.
- **Before first result.** While `valid`=0, all anodes are high.
- **Hex map (active-low, gfedcba):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- **Reset values.** `seg`=7'h7F, `an`=all 1, `carry`=0, `overflow`=0, `valid`=0, result=0, divider=0, index=0. Reset mid-operation discards any pending capture or compute immediately.
- **Latency.** `load` at edge N gives result, flags and `valid` at edge N+1. `seg`/`an` reflect the new result at edge N+2 when the active digit is unchanged.
- **Output registers.** `seg` and `an` are registered from the index and result, so anode and segment changes occur on the same edge. No ghosting cycle is permitted.
- **Dwell.** Each digit is active exactly REFRESH_DIV cycles. A full frame is DIGITS×REFRESH_DIV cycles.
- **Simultaneous events.** `load` coinciding with a divider wrap needs no special handling. Capture, compute and scan are independent.

## Structure
- Package `display_pkg`:
  - the hex-to-segment constants (SEG_BLANK = 7'h7F);
  - a function `nibble_to_seg`;
  - the parameter range checks as elaboration-time assertions.
- One sub-module, `scan_driver`: divider, index, blanking and registered `seg`/`an` outputs.
- The arithmetic and capture registers stay in the top module.

## Test plan
All scenarios use WIDTH=8, DIGITS=4, REFRESH_DIV=4.
- **Reset.** Assert `reset` mid-scan → `seg`=7F, `an`=1111, `carry`/`overflow`/`valid`=0 with no clock edge needed. After release with no `load`, `an` stays 1111.
- **Add with carry.** `a`=8'hC8, `b`=8'h3A, `sub`=0, `load` pulse → result 02, `carry`=1, `overflow`=0.
  - Digit 0 shows 2 (0100100) and digit 1 shows blank.
  - `an` cycles 1110 → 1111(blank) → 1111 → 1111, every 4 cycles.
- **Signed overflow.** `a`=8'h7F, `b`=8'h01, `sub`=0 → result 80, `overflow`=1, `carry`=0. Digits show "80", with digit 1 = 8 (0000000).
- **Subtract with borrow.** `a`=8'h05, `b`=8'h07, `sub`=1 → result FE, `carry`=0, `overflow`=0. Then `a`=8'h07, `b`=8'h05 → result 02, `carry`=1.
- **Latency and dwell.** Issue `load` and check result and flags at +1 edge. Check each `an` low exactly 4 cycles. Check `seg` and `an` change on the same edge.
- **Back-to-back loads.** `load` held 3 cycles with changing operands → last capture wins. `valid` stays 1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and helpers for the adder display: the active-low hex glyph table,
// the nibble decoder, and the legal-parameter predicate checked at elaboration.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

    function automatic bit params_ok(input int width, input int digits, input int div);
        return (width >= 4) && (width % 4 == 0) && (digits >= width / 4) && (div >= 2);
    endfunction

endpackage

// File: rtl/scan_driver.sv
// Time-multiplexed digit scan: divider, digit index, leading-zero blanking and the
// registered seg/an outputs that always change together.
module scan_driver
    import display_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  result_i,
    input  logic              valid_i,
    output logic [6:0]        seg_o,
    output logic [DIGITS-1:0] an_o
);

    localparam int NIB   = WIDTH / 4;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]  div_q, div_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [NIB-1:0]    show;

    // A digit is lit only if some nibble at or above it is nonzero; digit 0 always is.
    for (genvar i = 0; i < NIB; i++) begin : g_lz
        if (i == 0) begin : g_d0
            assign show[i] = 1'b1;
        end else begin : g_dn
            assign show[i] = |result_i[WIDTH-1:4*i];
        end
    end

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (valid_i) begin
            for (int i = 0; i < NIB; i++) begin
                if (idx_q == IDX_W'(i) && show[i]) begin
                    an_d[i] = 1'b0;
                    seg_d   = nibble_to_seg(result_i[4*i +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;

endmodule

// File: rtl/multi_digit_adder_display.sv
// Registered adder/subtractor: operands captured on load, result computed one edge
// later, then shown on a multiplexed hex display with carry and signed overflow flags.
module multi_digit_adder_display
    import display_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              sub,
    input  logic              load,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              carry,
    output logic              overflow,
    output logic              valid
);

    if (!params_ok(WIDTH, DIGITS, REFRESH_DIV)) begin : g_param_check
        $error("multi_digit_adder_display: illegal WIDTH/DIGITS/REFRESH_DIV");
    end

    logic [WIDTH-1:0] opa_q, opb_q, res_q;
    logic             sub_q, pend_q, carry_q, ovf_q, valid_q;
    logic [WIDTH-1:0] opb_eff;
    logic [WIDTH:0]   sum_d;
    logic             ovf_d;

    // Subtract is A + ~B + 1, so carry-out doubles as "no borrow".
    assign opb_eff = sub_q ? ~opb_q : opb_q;
    assign sum_d   = {1'b0, opa_q} + {1'b0, opb_eff} + (WIDTH + 1)'(sub_q);
    assign ovf_d   = (opa_q[WIDTH-1] == opb_eff[WIDTH-1]) && (sum_d[WIDTH-1] != opa_q[WIDTH-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opa_q   <= '0;
            opb_q   <= '0;
            sub_q   <= 1'b0;
            pend_q  <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (load) begin
                opa_q <= a;
                opb_q <= b;
                sub_q <= sub;
            end
            pend_q <= load;
            if (pend_q) begin
                res_q   <= sum_d[WIDTH-1:0];
                carry_q <= sum_d[WIDTH];
                ovf_q   <= ovf_d;
                valid_q <= 1'b1;
            end
        end
    end

    scan_driver #(
        .WIDTH      (WIDTH),
        .DIGITS     (DIGITS),
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan (
        .clk     (clk),
        .reset   (reset),
        .result_i(res_q),
        .valid_i (valid_q),
        .seg_o   (seg),
        .an_o    (an)
    );

    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_multi_digit_adder_display.sv
// Directed + random bench for the adder display at WIDTH=8, DIGITS=4, REFRESH_DIV=4,
// comparing flags and the scanned display against an arithmetic reference.
module tb_multi_digit_adder_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a, b;
    logic       sub, load;
    logic [6:0] seg;
    logic [3:0] an;
    logic       carry, overflow, valid;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_r;
    logic       exp_c, exp_o;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    multi_digit_adder_display #(.WIDTH(8), .DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .sub(sub), .load(load),
        .seg(seg), .an(an), .carry(carry), .overflow(overflow), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic in plain integers.
    function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic s,
                                  output logic [7:0] r, output logic c, output logic o);
        int ux, uy, sx, sy, sr;
        ux = int'(x); uy = int'(y);
        sx = (ux > 127) ? ux - 256 : ux;
        sy = (uy > 127) ? uy - 256 : uy;
        if (s) begin
            r = 8'(ux - uy); c = (ux >= uy); sr = sx - sy;
        end else begin
            r = 8'(ux + uy); c = (ux + uy) > 255; sr = sx + sy;
        end
        o = (sr > 127) || (sr < -128);
    endfunction

    // Over any 16-cycle window each of the 4 slots is active exactly 4 cycles.
    task automatic check_frame(input string tag, input logic [7:0] r);
        int  cnt0, cnt1, blanks;
        bit  shown1;
        cnt0 = 0; cnt1 = 0; blanks = 0;
        shown1 = (r[7:4] != 4'h0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin cnt0++; check({tag, "_seg_d0"}, 32'(seg), 32'(GLYPH[r[3:0]])); end
                4'b1101: begin cnt1++; check({tag, "_seg_d1"}, 32'(seg), 32'(GLYPH[r[7:4]])); end
                4'b1111: begin blanks++; check({tag, "_seg_blank"}, 32'(seg), 32'h7F); end
                default: check({tag, "_an_legal"}, 32'(an), 32'hF);
            endcase
        end
        check({tag, "_dwell_d0"}, 32'(cnt0), 32'd4);
        check({tag, "_dwell_d1"}, 32'(cnt1), shown1 ? 32'd4 : 32'd0);
        check({tag, "_dwell_blank"}, 32'(blanks), shown1 ? 32'd8 : 32'd12);
    endtask

    // Load pulse; flags must hold old values at edge N and switch at N+1.
    task automatic do_op(input string tag, input logic [7:0] x, input logic [7:0] y, input logic s);
        logic       old_c, old_o, old_v;
        old_c = exp_c; old_o = exp_o; old_v = valid;
        a = x; b = y; sub = s; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check({tag, "_hold_carry"}, 32'(carry), 32'(old_c));
        check({tag, "_hold_ovf"}, 32'(overflow), 32'(old_o));
        check({tag, "_hold_valid"}, 32'(valid), 32'(old_v));
        model(x, y, s, exp_r, exp_c, exp_o);
        @(negedge clk);
        check({tag, "_carry"}, 32'(carry), 32'(exp_c));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_o));
        check({tag, "_valid"}, 32'(valid), 32'd1);
        @(negedge clk);
        check_frame(tag, exp_r);
    endtask

    initial begin
        logic [7:0] x, y;
        logic       s;
        logic [7:0] bx [3];
        logic [7:0] by [3];
        logic       bs [3];
        logic [7:0] r2;
        logic       c2, o2;

        reset = 1'b1; a = '0; b = '0; sub = 1'b0; load = 1'b0;
        exp_r = '0; exp_c = 1'b0; exp_o = 1'b0;
        #1;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_valid", 32'(valid), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("idle_an", 32'(an), 32'hF);
            check("idle_valid", 32'(valid), 32'd0);
        end

        do_op("add_carry", 8'hC8, 8'h3A, 1'b0);
        check("add_carry_r", 32'(exp_r), 32'h02);
        do_op("ovf", 8'h7F, 8'h01, 1'b0);
        do_op("sub_borrow", 8'h05, 8'h07, 1'b1);
        do_op("sub_noborrow", 8'h07, 8'h05, 1'b1);
        do_op("sub_ovf", 8'h80, 8'h01, 1'b1);
        do_op("zero", 8'h00, 8'h00, 1'b0);

        for (int k = 0; k < 10; k++) begin
            x = 8'($urandom); y = 8'($urandom); s = 1'($urandom_range(0, 1));
            do_op($sformatf("rand%0d", k), x, y, s);
        end

        // Load held three cycles: each compute follows the capture one edge earlier.
        bx = '{8'hFF, 8'h40, 8'h9A};
        by = '{8'h01, 8'h40, 8'h0C};
        bs = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            a = bx[k]; b = by[k]; sub = bs[k]; load = 1'b1;
            @(negedge clk);
            if (k > 0) begin
                model(bx[k-1], by[k-1], bs[k-1], r2, c2, o2);
                check($sformatf("b2b_carry%0d", k), 32'(carry), 32'(c2));
                check($sformatf("b2b_ovf%0d", k), 32'(overflow), 32'(o2));
                check($sformatf("b2b_valid%0d", k), 32'(valid), 32'd1);
            end
        end
        load = 1'b0;
        @(negedge clk);
        model(bx[2], by[2], bs[2], exp_r, exp_c, exp_o);
        check("b2b_last_carry", 32'(carry), 32'(exp_c));
        check("b2b_last_ovf", 32'(overflow), 32'(exp_o));
        @(negedge clk);
        check_frame("b2b_last", exp_r);

        // Asynchronous reset mid-scan, applied away from any clock edge.
        do_op("pre_rst", 8'h7F, 8'h01, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_seg", 32'(seg), 32'h7F);
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_carry", 32'(carry), 32'd0);
        check("async_rst_ovf", 32'(overflow), 32'd0);
        check("async_rst_valid", 32'(valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_rst_an", 32'(an), 32'hF);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
